// File: rtl/sc_stream_counter_if.sv
// sc_stream_counter_if
// Purpose: bundles the measurement handshake and result bus of the
//          stochastic-to-binary stream counter.
// Signals:
//   start    - request a measurement window
//   bit_a    - reference stochastic stream
//   bit_b    - stochastic stream under test
//   busy     - window is being accumulated
//   done     - one-cycle pulse, results updated
//   count_a  - ones in bit_a over the last completed window
//   count_b  - ones in bit_b over the last completed window
//   abs_err  - |count_a - count_b|
//   a_lt_b   - count_a < count_b
//   mismatch - cycles in the window where bit_a != bit_b
// Modports: master drives the request and streams, slave is the counter.
interface sc_stream_counter_if #(
  parameter int W = 8
);
  logic         start;
  logic         bit_a;
  logic         bit_b;
  logic         busy;
  logic         done;
  logic [W-1:0] count_a;
  logic [W-1:0] count_b;
  logic [W-1:0] abs_err;
  logic         a_lt_b;
  logic [W-1:0] mismatch;

  modport master (
    output start, bit_a, bit_b,
    input  busy, done, count_a, count_b, abs_err, a_lt_b, mismatch
  );

  modport slave (
    input  start, bit_a, bit_b,
    output busy, done, count_a, count_b, abs_err, a_lt_b, mismatch
  );
endinterface

// File: rtl/sc_stream_counter.sv
// sc_stream_counter
// Purpose: counts the ones of a reference and a test stochastic bitstream
//          over a fixed window of WINDOW clock cycles and reports both
//          counts, their absolute difference, their ordering and the number
//          of cycles on which the streams disagreed.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high; clears state and all outputs
//   bus   - sc_stream_counter_if.slave (start/bit_a/bit_b in, results out)
//
// state | meaning
// IDLE  | waiting for start; results hold the last completed window
// ACCUM | sampling bit_a/bit_b once per edge until WINDOW samples are taken
module sc_stream_counter #(
  parameter int WINDOW = 15,
  parameter int W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  sc_stream_counter_if.slave  bus
);

  typedef enum logic {IDLE, ACCUM} state_t;

  // Sample counter value on the edge that takes the final sample.
  localparam logic [W-1:0] LAST = W'(WINDOW - 1);

  state_t       state;
  logic [W-1:0] cnt;
  logic [W-1:0] acc_a;
  logic [W-1:0] acc_b;
  logic [W-1:0] acc_m;

  logic         busy_r;
  logic         done_r;
  logic [W-1:0] count_a_r;
  logic [W-1:0] count_b_r;
  logic [W-1:0] abs_err_r;
  logic         a_lt_b_r;
  logic [W-1:0] mismatch_r;

  // Sums including the sample taken on the current edge; on the final edge
  // these are what gets published, so the last sample is never lost.
  logic [W-1:0] sum_a;
  logic [W-1:0] sum_b;
  logic [W-1:0] sum_m;
  logic [W-1:0] diff;

  always_comb begin
    sum_a = acc_a + {{(W-1){1'b0}}, bus.bit_a};
    sum_b = acc_b + {{(W-1){1'b0}}, bus.bit_b};
    sum_m = acc_m + {{(W-1){1'b0}}, bus.bit_a ^ bus.bit_b};
    diff  = (sum_a >= sum_b) ? (sum_a - sum_b) : (sum_b - sum_a);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      acc_a      <= '0;
      acc_b      <= '0;
      acc_m      <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      count_a_r  <= '0;
      count_b_r  <= '0;
      abs_err_r  <= '0;
      a_lt_b_r   <= 1'b0;
      mismatch_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          // The accepting edge only arms the window; streams are not sampled.
          if (bus.start) begin
            state  <= ACCUM;
            busy_r <= 1'b1;
            cnt    <= '0;
            acc_a  <= '0;
            acc_b  <= '0;
            acc_m  <= '0;
          end
        end
        ACCUM: begin
          acc_a <= sum_a;
          acc_b <= sum_b;
          acc_m <= sum_m;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state      <= IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            count_a_r  <= sum_a;
            count_b_r  <= sum_b;
            abs_err_r  <= diff;
            a_lt_b_r   <= (sum_a < sum_b);
            mismatch_r <= sum_m;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.count_a  = count_a_r;
  assign bus.count_b  = count_b_r;
  assign bus.abs_err  = abs_err_r;
  assign bus.a_lt_b   = a_lt_b_r;
  assign bus.mismatch = mismatch_r;

endmodule

// File: tb/tb_sc_stream_counter.sv
// tb_sc_stream_counter
// Purpose: self-checking bench for sc_stream_counter. Two instances share
//          the same stimulus: one with WINDOW=15, one with WINDOW=14.
// Ports: none (top-level bench).
module tb_sc_stream_counter;

  logic clk;
  logic reset;
  logic start;
  logic bit_a;
  logic bit_b;

  int checks = 0;
  int errors = 0;

  sc_stream_counter_if #(.W(8)) bus15 ();
  sc_stream_counter_if #(.W(8)) bus14 ();

  assign bus15.start = start;
  assign bus15.bit_a = bit_a;
  assign bus15.bit_b = bit_b;
  assign bus14.start = start;
  assign bus14.bit_a = bit_a;
  assign bus14.bit_b = bit_b;

  sc_stream_counter #(.WINDOW(15), .W(8)) dut15 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus15)
  );

  sc_stream_counter #(.WINDOW(14), .W(8)) dut14 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus14)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ca;
    int cb;
    int ae;
    int lt;
    int mm;
  } res_t;

  typedef struct {
    string       name;
    int          n;
    logic [31:0] pa;
    logic [31:0] pb;
    logic [31:0] sm;
    res_t        exp;
  } vec_t;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic logic get_busy(input int n);
    return (n == 14) ? bus14.busy : bus15.busy;
  endfunction

  function automatic logic get_done(input int n);
    return (n == 14) ? bus14.done : bus15.done;
  endfunction

  function automatic res_t get_res(input int n);
    res_t r;
    if (n == 14) begin
      r.ca = int'(bus14.count_a); r.cb = int'(bus14.count_b);
      r.ae = int'(bus14.abs_err); r.lt = int'(bus14.a_lt_b);
      r.mm = int'(bus14.mismatch);
    end else begin
      r.ca = int'(bus15.count_a); r.cb = int'(bus15.count_b);
      r.ae = int'(bus15.abs_err); r.lt = int'(bus15.a_lt_b);
      r.mm = int'(bus15.mismatch);
    end
    return r;
  endfunction

  task automatic chk_res(input string nm, input res_t act, input res_t expv);
    chk({nm, ".count_a"},  act.ca, expv.ca);
    chk({nm, ".count_b"},  act.cb, expv.cb);
    chk({nm, ".abs_err"},  act.ae, expv.ae);
    chk({nm, ".a_lt_b"},   act.lt, expv.lt);
    chk({nm, ".mismatch"}, act.mm, expv.mm);
  endtask

  // Called #1 after a rising edge with the DUT idle. Edge k accepts start;
  // bit i of pa/pb is the stream value sampled at edge k+1+i; bit i of sm
  // raises start before edge k+i (extra requests while busy).
  task automatic run_window(input int n, input logic [31:0] pa,
                            input logic [31:0] pb, input logic [31:0] sm,
                            output int bc, output int dc, output int di,
                            output res_t r);
    logic [31:0] sh;
    start = 1'b1; bit_a = 1'b0; bit_b = 1'b0;
    @(posedge clk); #1;
    bc = 0; dc = 0; di = -1;
    r = '{default: -1};
    for (int i = 0; i <= 2 * n + 3; i++) begin
      if (get_busy(n)) bc++;
      if (get_done(n)) begin
        dc++;
        di = i;
        r  = get_res(n);
      end
      sh    = sm >> (i + 1);
      start = sh[0];
      sh    = pa >> i;
      bit_a = (i < n) ? sh[0] : 1'b0;
      sh    = pb >> i;
      bit_b = (i < n) ? sh[0] : 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0; bit_a = 1'b0; bit_b = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    int   bc, dc, di, nd, last_d;
    res_t r, e;
    logic [3:0]  q1, q2;
    logic [31:0] la, lb;
    int   pc_a, pc_b, pc_m;

    vecs[0] = '{"ones_zeros",   15, 32'h7FFF, 32'h0000, 32'h0,    '{15, 0, 15, 0, 15}};
    vecs[1] = '{"zeros_ones",   15, 32'h0000, 32'h7FFF, 32'h0,    '{0, 15, 15, 1, 15}};
    vecs[2] = '{"all_ones",     15, 32'h7FFF, 32'h7FFF, 32'h0,    '{15, 15, 0, 0, 0}};
    vecs[3] = '{"byte_nibble",  15, 32'h00FF, 32'h0F0F, 32'h0,    '{8, 8, 0, 0, 8}};
    vecs[4] = '{"small_lt",     15, 32'h0001, 32'h0007, 32'h0,    '{1, 3, 2, 1, 2}};
    vecs[5] = '{"last_sample",  15, 32'h4000, 32'h0000, 32'h0,    '{1, 0, 1, 0, 1}};
    vecs[6] = '{"first_sample", 15, 32'h0000, 32'h0001, 32'h0,    '{0, 1, 1, 1, 1}};
    vecs[7] = '{"start_busy",   15, 32'h7FFF, 32'h0000, 32'h0408, '{15, 0, 15, 0, 15}};
    vecs[8] = '{"equal_w14",    14, 32'h1555, 32'h2AAA, 32'h0,    '{7, 7, 0, 0, 14}};

    reset = 1'b1; start = 1'b0; bit_a = 1'b0; bit_b = 1'b0;
    #12;
    e = '{0, 0, 0, 0, 0};
    chk_res("reset15", get_res(15), e);
    chk_res("reset14", get_res(14), e);
    chk("reset.busy", int'(bus15.busy), 0);
    chk("reset.done", int'(bus15.done), 0);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[v]) begin
      run_window(vecs[v].n, vecs[v].pa, vecs[v].pb, vecs[v].sm, bc, dc, di, r);
      chk({vecs[v].name, ".busy_cycles"}, bc, vecs[v].n);
      chk({vecs[v].name, ".done_count"},  dc, 1);
      chk({vecs[v].name, ".done_edge"},   di, vecs[v].n);
      chk_res(vecs[v].name, r, vecs[v].exp);
    end

    // LFSR reference/test pair: x^4+x+1 Galois LFSRs (taps 0011), stepped
    // once per edge starting at the start-accept edge.
    q1 = 4'd11; q2 = 4'd1; la = '0; lb = '0;
    for (int i = 0; i < 15; i++) begin
      q1 = {q1[2:0], 1'b0} ^ (q1[3] ? 4'b0011 : 4'b0000);
      q2 = {q2[2:0], 1'b0} ^ (q2[3] ? 4'b0011 : 4'b0000);
      la[i] = q1[1];
      lb[i] = q1[1] & q2[1];
    end
    pc_a = $countones(la); pc_b = $countones(lb); pc_m = $countones(la ^ lb);
    e = '{pc_a, pc_b, (pc_a > pc_b) ? pc_a - pc_b : pc_b - pc_a,
          (pc_a < pc_b) ? 1 : 0, pc_m};
    run_window(15, la, lb, 32'h0, bc, dc, di, r);
    chk("lfsr.count_a_period", r.ca, 8);
    chk("lfsr.done_edge", di, 15);
    chk_res("lfsr", r, e);
    chk("lfsr.mismatch_eq_abs", r.mm, r.ae);

    // Reset mid-window after sample 7, between edges.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bit_a = 1'b1; bit_b = 1'b1;
    repeat (7) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    e = '{0, 0, 0, 0, 0};
    chk_res("midreset", get_res(15), e);
    chk("midreset.busy", int'(bus15.busy), 0);
    chk("midreset.done", int'(bus15.done), 0);
    @(posedge clk); #2 reset = 1'b0;
    bit_a = 1'b0; bit_b = 1'b0;
    @(posedge clk); #1;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus15.done) nd++;
      @(posedge clk); #1;
    end
    chk("midreset.no_done", nd, 0);
    run_window(15, 32'h0003, 32'h0000, 32'h0, bc, dc, di, r);
    chk("after_reset.busy_cycles", bc, 15);
    chk("after_reset.done_edge", di, 15);
    chk_res("after_reset", r, '{2, 0, 2, 0, 2});

    // Back-to-back: start held high, both streams at 1.
    start = 1'b1; bit_a = 1'b1; bit_b = 1'b1;
    @(posedge clk); #1;
    nd = 0; last_d = -1;
    for (int i = 0; i < 60; i++) begin
      if (bus15.done) begin
        nd++;
        if (last_d < 0) chk("b2b.first_done", i, 15);
        else            chk("b2b.period", i - last_d, 16);
        last_d = i;
        chk_res("b2b", get_res(15), '{15, 15, 0, 0, 0});
      end
      @(posedge clk); #1;
    end
    chk("b2b.done_count", nd, 3);
    start = 1'b0; bit_a = 1'b0; bit_b = 1'b0;
    repeat (20) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_stream_counter.md
# sc_stream_counter

Stochastic-to-binary converter for the error-analysis datapath. It sits directly downstream of the LFSR-based stochastic bitstream generators. It consumes two single-bit streams, an exact reference stream and a stream under test (e.g. an AND of two LFSR-driven streams), over a fixed window of clock cycles. It reports the ones-count of each stream, their absolute difference, and the number of cycles on which the streams disagreed.

## Interface
Parameters:
- WINDOW, default 15: samples per measurement; one full period of a 4-bit maximal LFSR. Legal range is 1 to 2^W − 1.
- W, default 8: width of every count/result output. Must satisfy 2^W > WINDOW.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs immediately.
- start  input  1  request a measurement; sampled on rising edge.
- bit_a  input  1  reference stochastic stream.
- bit_b  input  1  stream under test.
- busy  output  1  high while a window is being accumulated.
- done  output  1  one-cycle pulse: results updated.
- count_a  output  W  ones in bit_a over last completed window.
- count_b  output  W  ones in bit_b over last completed window.
- abs_err  output  W  |count_a − count_b|.
- a_lt_b  output  1  1 when count_a < count_b.
- mismatch  output  W  cycles in window where bit_a != bit_b.

## Operation
- FSM has two states: IDLE and ACCUM. Internal registers are the sample counter (W bits), acc_a, acc_b and acc_m (W bits each).
- IDLE behaviour:
  - busy = 0.
  - If start = 1 at an edge, move to ACCUM and clear the sample counter, acc_a, acc_b and acc_m.
  - That same edge does not sample the bit streams.
- ACCUM behaviour, at each edge:
  - acc_a += bit_a.
  - acc_b += bit_b.
  - acc_m += (bit_a ^ bit_b).
  - The sample counter increments.
- On the edge that takes sample number WINDOW:
  - Load the result outputs from the final sums, including that last sample.
  - Assert done for the following cycle.
  - Return to IDLE.
- start is ignored while in ACCUM. There is no queueing and no restart.
- Result outputs hold their value until the next done or until reset.
- Arithmetic:
  - Accumulators never exceed WINDOW, so no saturation logic is required.
  - abs_err is computed from the final sums: the larger sum minus the smaller.
  - a_lt_b is a strict comparison, so equal counts give a_lt_b = 0 and abs_err = 0.
- Reset asserted mid-window:
  - FSM returns to IDLE.
  - The partial window is discarded.
  - All outputs go to 0, with no done pulse.
- Reset values: busy 0, done 0, count_a 0, count_b 0, abs_err 0, a_lt_b 0, mismatch 0, FSM IDLE.

## Timing
- Let edge k be the edge where start is accepted in IDLE.
- busy rises after edge k and stays high through edges k+1 … k+WINDOW−1.
- Samples are taken at edges k+1 … k+WINDOW: exactly WINDOW samples.
- After edge k+WINDOW:
  - All result outputs are valid.
  - done = 1 for one cycle.
  - busy = 0.
- Back-to-back operation:
  - start held high through done is accepted at edge k+WINDOW+1.
  - The next window samples edges k+WINDOW+2 … k+2·WINDOW+1, giving a one-edge gap per window.
- Outputs are all registered, with no combinational path from inputs to outputs.
- Reset is asynchronous: outputs clear without waiting for a clock edge.
- After reset deasserts, the first start is accepted on the first rising edge at which start = 1.

## Test plan
- Constant streams:
  - Stimulus: bit_a = 1, bit_b = 0, WINDOW = 15, single start pulse.
  - Required: count_a = 15, count_b = 0, abs_err = 15, a_lt_b = 0, mismatch = 15.
  - done is a single-cycle pulse one cycle after edge k+15; busy was high for exactly 15 cycles.
- Reference-and-test pair:
  - Stimulus: bit_a = q[1] of 4-bit LFSR (taps 0011, seed 11); bit_b = bit_a & q[1] of a second LFSR (seed 1); start at the same edge as the first LFSR step.
  - Required: count_a = 8, the ones per maximal 4-bit period. count_b, abs_err and mismatch match the bench's software model; mismatch = abs_err because bit_b ≤ bit_a.
- Equal counts:
  - Stimulus: bit_a alternating 1,0,…; bit_b alternating 0,1,…; WINDOW = 14.
  - Required: count_a = count_b = 7, abs_err = 0, a_lt_b = 0, mismatch = 14.
- Start while busy:
  - Stimulus: pulse start again at edges k+3 and k+10.
  - Required: exactly one done at k+15 and no second window; busy profile is unchanged.
- Back-to-back:
  - Stimulus: hold start = 1 continuously with bit_a = 1, bit_b = 1.
  - Required: done pulses every 16 cycles, each reporting count_a = count_b = 15, abs_err = 0, mismatch = 0.
- Reset mid-window:
  - Stimulus: assert reset between clock edges at sample 7.
  - Required: all outputs 0 immediately, with no done pulse. A new start then yields a full 15-sample result unaffected by the aborted window.
